// File: rtl/debug_pkg.sv
// Shared definitions for the debug byte transmit path: sync byte, scheduler
// state encoding and default frame/gap sizing.
package debug_pkg;

   localparam logic [7:0] SYNC_BYTE      = 8'hFF;
   localparam int         DEF_NUM_BYTES  = 8;
   localparam int         DEF_GAP_CYCLES = 8192;
   localparam int         GAP_W          = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_CKSUM = 2'd2,
      ST_TRAIL = 2'd3
   } tx_state_t;

endpackage

// File: rtl/debug_gap_timer.sv
// Loadable down-counter that enforces the minimum spacing between UART strobes.
// Counts down to zero and holds there; expired is high while the count is zero.
module debug_gap_timer
   import debug_pkg::*;
#(
   parameter int W = GAP_W
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/debug_tx_sched.sv
// Debug frame scheduler: snapshots dbg_data and sends data bytes, an optional
// XOR checksum (DEBUG_TX_CKSUM_EN) and a 0xFF trailer, sharing the UART with replies.
module debug_tx_sched
   import debug_pkg::*;
#(
   parameter int NUM_BYTES  = DEF_NUM_BYTES,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   enable,
   input  logic [8*NUM_BYTES-1:0] dbg_data,
   input  logic                   reply_valid,
   input  logic [7:0]             reply_data,
   output logic                   reply_ready,
   input  logic                   uart_tx_ready,
   output logic                   uart_tx_strobe,
   output logic [7:0]             uart_tx_data,
   output logic                   frame_done
);

   localparam int                IDX_W    = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   tx_state_t                   state, state_nxt;
   logic [IDX_W-1:0]            idx;
   logic [NUM_BYTES-1:0][7:0]   snap;
   logic                        gap_ok;
   logic                        issue;
   logic                        fire;
   logic                        take_reply;
   logic                        start_frame;
   logic                        frame_end;
   logic [7:0]                  byte_nxt;

   debug_gap_timer #(
      .W (GAP_W)
   ) u_gap_timer (
      .clk        (clk),
      .resetn     (resetn),
      .load       (fire),
      .load_value (GAP_LOAD),
      .expired    (gap_ok)
   );

   assign issue = uart_tx_ready && gap_ok;

`ifdef DEBUG_TX_CKSUM_EN
   logic [7:0] cksum;

   always_comb begin
      cksum = 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
         cksum = cksum ^ snap[i];
      end
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (issue && !reply_valid && enable) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (issue && (idx == LAST_IDX)) begin
`ifdef DEBUG_TX_CKSUM_EN
               state_nxt = ST_CKSUM;
`else
               state_nxt = ST_TRAIL;
`endif
            end
         end
`ifdef DEBUG_TX_CKSUM_EN
         ST_CKSUM: begin
            if (issue) begin
               state_nxt = ST_TRAIL;
            end
         end
`endif
         ST_TRAIL: begin
            if (issue) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Replies only win the transmitter in IDLE, so a frame is never split.
   always_comb begin
      fire        = 1'b0;
      take_reply  = 1'b0;
      start_frame = 1'b0;
      frame_end   = 1'b0;
      byte_nxt    = uart_tx_data;
      case (state)
         ST_IDLE: begin
            if (issue && reply_valid) begin
               fire       = 1'b1;
               take_reply = 1'b1;
               byte_nxt   = reply_data;
            end else if (issue && enable) begin
               fire        = 1'b1;
               start_frame = 1'b1;
               byte_nxt    = dbg_data[7:0];
            end
         end
         ST_DATA: begin
            if (issue) begin
               fire     = 1'b1;
               byte_nxt = snap[idx];
            end
         end
`ifdef DEBUG_TX_CKSUM_EN
         ST_CKSUM: begin
            if (issue) begin
               fire     = 1'b1;
               byte_nxt = cksum;
            end
         end
`endif
         ST_TRAIL: begin
            if (issue) begin
               fire      = 1'b1;
               frame_end = 1'b1;
               byte_nxt  = SYNC_BYTE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         uart_tx_strobe <= 1'b0;
         uart_tx_data   <= 8'h00;
         reply_ready    <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         uart_tx_strobe <= fire;
         reply_ready    <= take_reply;
         frame_done     <= frame_end;
         if (fire) begin
            uart_tx_data <= byte_nxt;
         end
      end
   end

   // NOTE: the snapshot bank is small, so it is reset along with the control
   // state; a larger buffer would be left unreset and qualified by state instead.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         snap <= '0;
         idx  <= '0;
      end else if (start_frame) begin
         snap <= dbg_data;
         idx  <= IDX_W'(1);
      end else if ((state == ST_DATA) && fire && (idx != LAST_IDX)) begin
         idx <= idx + 1'b1;
      end
   end

endmodule
